// File: rtl/maze_map.sv
// Wall/visited map for the maze solver: row-wise load, 1-cycle solver read/mark,
// then a row-major dump of visited cells. Optional MAZE_MAP_VISIT_COUNT_EN adds visit_count.
module maze_map #(
  parameter int ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [2**ADDR_W-1:0]   load_data,
  input  logic [ADDR_W-1:0]      row,
  input  logic [ADDR_W-1:0]      col,
  input  logic                   maze_oe,
  input  logic                   maze_we,
  output logic                   maze_in,
  input  logic                   solver_done,
  output logic                   map_ready,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [ADDR_W-1:0]      dump_row,
  output logic [ADDR_W-1:0]      dump_col,
  output logic                   dump_done
`ifdef MAZE_MAP_VISIT_COUNT_EN
  ,
  output logic [2*ADDR_W:0]      visit_count
`endif
);
  localparam int DIM = 2**ADDR_W;
  localparam int IW  = 2*ADDR_W;

  typedef enum logic [2:0] {LOAD, RUN, SCAN, EMIT, FIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] load_row;
  logic [IW-1:0]     scan_idx;
  logic [ADDR_W-1:0] scan_r, scan_c;
  logic              scan_hit, scan_last;
  logic [DIM-1:0]    wall    [DIM];
  logic [DIM-1:0]    visited [DIM];

  assign {scan_r, scan_c} = scan_idx;
  assign scan_hit  = visited[scan_r][scan_c];
  assign scan_last = &scan_idx;

  assign load_ready = (state == LOAD);
  assign map_ready  = (state != LOAD);
  assign dump_valid = (state == EMIT);
  assign dump_done  = (state == FIN);

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (load_valid && (&load_row)) state_nx = RUN;
      RUN:  if (solver_done) state_nx = SCAN;
      SCAN: begin
        if (scan_hit)       state_nx = EMIT;
        else if (scan_last) state_nx = FIN;
      end
      EMIT: if (dump_ready) state_nx = scan_last ? FIN : SCAN;
      FIN:  state_nx = FIN;
      default: state_nx = LOAD;
    endcase
  end

  // Wall contents survive reset; only the loader writes them.
  always_ff @(posedge clk) begin
    if (state == LOAD && load_valid) wall[load_row] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_row <= '0;
      scan_idx <= '0;
      dump_row <= '0;
      dump_col <= '0;
      maze_in  <= 1'b1;
      for (int i = 0; i < DIM; i++) visited[i] <= '0;
    end else begin
      state <= state_nx;
      // Outside RUN every read sees a wall so a premature solver cannot move.
      if (maze_oe) maze_in <= (state == RUN) ? wall[row][col] : 1'b1;
      case (state)
        LOAD: if (load_valid) load_row <= load_row + 1'b1;
        RUN: begin
          if (maze_we)     visited[row][col] <= 1'b1;
          if (solver_done) scan_idx <= '0;
        end
        SCAN: begin
          if (scan_hit) begin
            dump_row <= scan_r;
            dump_col <= scan_c;
          end else if (!scan_last) begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        EMIT: if (dump_ready && !scan_last) scan_idx <= scan_idx + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MAZE_MAP_VISIT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      visit_count <= '0;
    else if (state == RUN && maze_we && !visited[row][col])
      visit_count <= visit_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_maze_map.sv
// Self-checking bench for maze_map: directed tables/sequences plus random
// read/write traffic against a cell-level map model.
module tb_maze_map;
  localparam int AW  = 6;
  localparam int DIM = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [DIM-1:0] load_data = '0;
  logic [AW-1:0]  row = '0, col = '0;
  logic           maze_oe = 1'b0, maze_we = 1'b0;
  logic           maze_in;
  logic           solver_done = 1'b0;
  logic           map_ready;
  logic           dump_valid;
  logic           dump_ready = 1'b0;
  logic [AW-1:0]  dump_row, dump_col;
  logic           dump_done;
`ifdef MAZE_MAP_VISIT_COUNT_EN
  logic [2*AW:0]  visit_count;
`endif

  maze_map #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .solver_done(solver_done), .map_ready(map_ready),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_row(dump_row), .dump_col(dump_col), .dump_done(dump_done)
`ifdef MAZE_MAP_VISIT_COUNT_EN
    , .visit_count(visit_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DIM-1:0] wall_m [DIM];
  bit             vis_m  [DIM][DIM];
  int             vcount_m;

  typedef struct {
    logic [AW-1:0] r;
    logic [AW-1:0] c;
    logic          exp;
  } rd_vec_t;
  rd_vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) vis_m[r][c] = 1'b0;
    vcount_m = 0;
  endtask

  task automatic new_walls();
    for (int r = 0; r < DIM; r++) wall_m[r] = {$urandom, $urandom};
    wall_m[5][7] = 1'b1;
    wall_m[5][8] = 1'b0;
  endtask

  task automatic do_reset();
    load_valid = 0; maze_oe = 0; maze_we = 0; solver_done = 0; dump_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    clear_model();
  endtask

  task automatic load_map(input bit stalls);
    for (int r = 0; r < DIM; r++) begin
      if (stalls) begin
        while ($urandom_range(0, 2) == 0) begin
          load_valid = 0;
          tick();
          chk("load_ready_stall", load_ready, 1);
        end
      end
      load_valid = 1;
      load_data  = wall_m[r];
      chk("load_ready_beat", load_ready, 1);
      chk("map_ready_loading", map_ready, 0);
      tick();
    end
    chk("map_ready_after_load", map_ready, 1);
    chk("load_ready_after_load", load_ready, 0);
    // Extra beats after the map is full must not touch wall storage.
    load_data = {$urandom, $urandom};
    tick();
    load_data = ~load_data;
    tick();
    load_valid = 0;
  endtask

  task automatic rd(input logic [AW-1:0] r, input logic [AW-1:0] c, input logic exp, input string nm);
    row = r; col = c; maze_oe = 1;
    tick();
    maze_oe = 0;
    chk(nm, maze_in, exp);
  endtask

  task automatic wr(input logic [AW-1:0] r, input logic [AW-1:0] c);
    row = r; col = c; maze_we = 1;
    tick();
    maze_we = 0;
    if (!vis_m[r][c]) vcount_m++;
    vis_m[r][c] = 1'b1;
  endtask

  task automatic done_pulse();
    solver_done = 1;
    tick();
    solver_done = 0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!dump_valid && n < 5000) begin
      tick();
      n++;
    end
    chk(nm, dump_valid, 1);
  endtask

  task automatic collect(input string nm);
    logic [2*AW-1:0] expq [$];
    logic [2*AW-1:0] got  [$];
    int cyc = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (vis_m[r][c]) expq.push_back({r[AW-1:0], c[AW-1:0]});
    while (!dump_done && cyc < 6000) begin
      dump_ready = 1'($urandom_range(0, 1));
      if (dump_valid && dump_ready) got.push_back({dump_row, dump_col});
      tick();
      cyc++;
    end
    dump_ready = 0;
    chk({nm, "_done"}, dump_done, 1);
    chk({nm, "_count"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      chk({nm, "_coord"}, got[i], expq[i]);
    chk({nm, "_valid_low"}, dump_valid, 0);
    chk({nm, "_map_ready"}, map_ready, 1);
  endtask

  initial begin
    logic [AW-1:0] sr, sc;
    clear_model();
    new_walls();

    // Reset values while rst_n is held low.
    #12;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_maze_in", maze_in, 1);
    chk("rst_map_ready", map_ready, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_row", dump_row, 0);
    chk("rst_dump_col", dump_col, 0);
    chk("rst_dump_done", dump_done, 0);
`ifdef MAZE_MAP_VISIT_COUNT_EN
    chk("rst_visit_count", visit_count, 0);
`endif
    tick();
    rst_n = 1;

    // LOAD: reads see walls, writes and solver_done are ignored.
    row = 10; col = 10; maze_oe = 1; maze_we = 1; solver_done = 1;
    tick();
    maze_oe = 0; maze_we = 0; solver_done = 0;
    chk("load_read_wall", maze_in, 1);
    chk("load_done_ignored", load_ready, 1);
    chk("load_map_ready_low", map_ready, 0);

    load_map(1'b0);

    tbl[0] = '{5, 7, 1'b1};
    tbl[1] = '{5, 8, 1'b0};
    tbl[2] = '{0, 0, wall_m[0][0]};
    tbl[3] = '{63, 63, wall_m[63][63]};
    tbl[4] = '{0, 63, wall_m[0][63]};
    tbl[5] = '{63, 0, wall_m[63][0]};
    for (int i = 0; i < 6; i++) rd(tbl[i].r, tbl[i].c, tbl[i].exp, "table_read");
    row = 5; col = 7;
    tick();
    chk("read_hold", maze_in, tbl[5].exp);

    wr(3, 4);
    wr(0, 63);
    wr(3, 4);
    done_pulse();
    wait_valid("first_emit");
    sr = dump_row; sc = dump_col;
    chk("first_emit_row", sr, 0);
    chk("first_emit_col", sc, 63);
    dump_ready = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", dump_valid, 1);
      chk("stall_coord", {dump_row, dump_col}, {sr, sc});
    end
    collect("dump1");
`ifdef MAZE_MAP_VISIT_COUNT_EN
    chk("visit_count1", visit_count, 2);
`endif
    rd(5, 8, 1'b1, "fin_read_wall");
    wr(7, 7);
    vis_m[7][7] = 1'b0;
    vcount_m = 2;
    chk("fin_sticky", dump_done, 1);
`ifdef MAZE_MAP_VISIT_COUNT_EN
    chk("visit_count_frozen", visit_count, 2);
`endif

    // Random traffic against the model, with load stalls.
    do_reset();
    new_walls();
    load_map(1'b1);
    for (int i = 0; i < 80; i++) begin
      sr = AW'($urandom_range(0, DIM - 1));
      sc = AW'($urandom_range(0, DIM - 1));
      case ($urandom_range(0, 2))
        0: rd(sr, sc, wall_m[sr][sc], "rand_read");
        1: wr(sr, sc);
        default: begin
          row = sr; col = sc; maze_oe = 1; maze_we = 1;
          tick();
          maze_oe = 0; maze_we = 0;
          chk("rand_rw_read", maze_in, wall_m[sr][sc]);
          if (!vis_m[sr][sc]) vcount_m++;
          vis_m[sr][sc] = 1'b1;
        end
      endcase
    end
    // Write on the same edge as solver_done must still land.
    row = 62; col = 1; maze_we = 1; solver_done = 1;
    tick();
    maze_we = 0; solver_done = 0;
    if (!vis_m[62][1]) vcount_m++;
    vis_m[62][1] = 1'b1;
    collect("dump_rand");
`ifdef MAZE_MAP_VISIT_COUNT_EN
    chk("visit_count_rand", visit_count, vcount_m);
`endif

    // Reset in the middle of a dump.
    do_reset();
    load_map(1'b1);
    wr(1, 1);
    wr(2, 2);
    wr(40, 5);
    done_pulse();
    wait_valid("mid_first");
    dump_ready = 1;
    tick();
    dump_ready = 0;
    wait_valid("mid_second");
    rst_n = 0;
    #1;
    chk("mid_rst_dump_valid", dump_valid, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    chk("mid_rst_map_ready", map_ready, 0);
    chk("mid_rst_dump_done", dump_done, 0);
    tick();
    rst_n = 1;
    clear_model();
    load_map(1'b0);
    done_pulse();
    collect("dump_empty");
`ifdef MAZE_MAP_VISIT_COUNT_EN
    chk("visit_count_empty", visit_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
